pipelined_decode: RTL and testbench
===================================

# pipelined_decode

Instruction-decode stage for the pipelined MIPS datapath: decodes a 32-bit instruction into control lines, reads two operands from an internal register file, sign- or zero-extends the immediate, and registers everything into the ID/EX pipeline register. It sits between the IF/ID register and the execute stage. It accepts writeback from the WB stage with same-cycle write-through, detects load-use hazards and inserts bubbles, and honours external stall and flush.

## Interface
- DATA_W, 32: register and operand width; immediate is extended to DATA_W.
- REG_ADDR_W, 5: register address width; register file depth is 2**REG_ADDR_W.
- BYPASS, 1: 1 = a WB write to a register being read in the same cycle is forwarded to the read data; 0 = read returns the old value.

Ports:
- Clk  in  1  clock, rising edge.
- Reset  in  1  asynchronous, active-high.
- Instruction  in  32  IF/ID instruction.
- InstrValid  in  1  Instruction is valid.
- Stall  in  1  external stall: hold ID/EX.
- Flush  in  1  squash the instruction in decode.
- WB_RegWrite  in  1  writeback enable.
- WB_WriteReg  in  REG_ADDR_W  writeback address.
- WB_WriteData  in  DATA_W  writeback data.
- EX_Valid  out  1  ID/EX holds a real instruction.
- EX_ControlLines  out  12  {RegDst, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, Jump, ALUOp[3:0]}.
- EX_ReadData1, EX_ReadData2  out  DATA_W  operands rs, rt.
- EX_Imm  out  DATA_W  extended immediate.
- EX_shamt  out  5  Instruction[10:6].
- EX_Rs, EX_Rt, EX_Rd  out  REG_ADDR_W  register fields, for forwarding.
- HazardStall  out  1  combinational; 1 = upstream must hold PC and IF/ID this cycle.

## Operation
- Decode by opcode Instruction[31:26]. Unlisted bits are 0.
  - 000000 R-type: RegDst, RegWrite, ALUOp=1111 (use funct).
  - 100011 lw: ALUSrc, MemtoReg, RegWrite, MemRead, ALUOp=0010.
  - 101011 sw: ALUSrc, MemWrite, ALUOp=0010.
  - 000100 beq: Branch, ALUOp=0110.
  - 001000 addi: ALUSrc, RegWrite, ALUOp=0010.
  - 001100 andi: ALUSrc, RegWrite, ALUOp=0000.
  - 001101 ori: ALUSrc, RegWrite, ALUOp=0001.
  - 000010 j: Jump.
  - Any other opcode: all control lines 0, EX_Valid still 1 (NOP).
- Immediate: andi/ori zero-extend Instruction[15:0]; all others sign-extend.
- Register fields are Instruction[25:21], [20:16], [15:11], truncated or zero-padded to REG_ADDR_W.
- Register file:
  - Written on the rising edge when WB_RegWrite=1 and WB_WriteReg≠0.
  - Register 0 always reads 0.
  - With BYPASS=1, a read address equal to a nonzero WB_WriteReg under WB_RegWrite returns WB_WriteData.
  - Writes occur regardless of Stall, Flush or HazardStall.
- Load-use hazard: HazardStall = InstrValid & EX_Valid & EX_ControlLines[7] (MemRead) & EX_Rt≠0 & (EX_Rt==rs | EX_Rt==rt).
- ID/EX update per rising edge, in priority order:
  1. Flush: EX_Valid←0 and control←0; the other outputs are don't-care but are loaded.
  2. Stall: all ID/EX outputs hold.
  3. HazardStall: bubble (EX_Valid←0, control←0).
  4. Otherwise: load the decoded values; EX_Valid←InstrValid, and control←0 if InstrValid=0.

## Timing
- Reset (asynchronous) sets all ID/EX outputs and all registers to 0.
- Decode latency: 1 cycle. An instruction presented in cycle N appears on the EX_* outputs after edge N+1.
- A WB write at edge N is visible to a read in cycle N+1. With BYPASS=1 it is also visible in cycle N itself.
- HazardStall is asserted for exactly 1 cycle per load-use pair: after the bubble, EX_Valid=0, so the hazard clears.
- Stall and HazardStall asserted together: Stall wins and ID/EX holds. HazardStall remains asserted because it is computed from the held state.
- Reset released mid-stream: the first valid instruction loads normally on the next edge.

## Test plan
- Reset, then write reg17=5 and reg18=7 via WB. Present 000000_10001_10010_01000_00000_100000 (add) -> next cycle EX_ReadData1=5, EX_ReadData2=7, EX_ControlLines=1001_0000_1111, EX_Rd=8, EX_Valid=1.
- Same-cycle bypass: WB writes reg9=0xDEADBEEF while decoding a read of rs=9 -> EX_ReadData1=0xDEADBEEF. With BYPASS=0 -> the old value 0.
- Immediates: addi with imm 0xFFFF -> EX_Imm=0xFFFFFFFF. ori with imm 0xFFFF -> EX_Imm=0x0000FFFF.
- Load-use hazard: lw rt=8, then add rs=8 -> HazardStall=1 for one cycle, one bubble (EX_Valid=0), then the add loads. Repeating with rt=0 -> no stall.
- Register 0: WB write of 0x1234 to reg0, then read rs=0 -> EX_ReadData1=0.
- Control: Stall held for 3 cycles -> EX outputs unchanged. Flush together with Stall -> EX_Valid=0. Asynchronous Reset pulse mid-stream -> all outputs 0 immediately.

Source files
------------

// File: rtl/pipelined_decode.sv
// Instruction-decode stage: control decode, register file read with optional
// same-cycle writeback bypass, immediate extension, load-use bubble insertion
// and the ID/EX pipeline register.
module pipelined_decode #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int BYPASS     = 1
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic [31:0]           Instruction,
    input  logic                  InstrValid,
    input  logic                  Stall,
    input  logic                  Flush,
    input  logic                  WB_RegWrite,
    input  logic [REG_ADDR_W-1:0] WB_WriteReg,
    input  logic [DATA_W-1:0]     WB_WriteData,
    output logic                  EX_Valid,
    output logic [11:0]           EX_ControlLines,
    output logic [DATA_W-1:0]     EX_ReadData1,
    output logic [DATA_W-1:0]     EX_ReadData2,
    output logic [DATA_W-1:0]     EX_Imm,
    output logic [4:0]            EX_shamt,
    output logic [REG_ADDR_W-1:0] EX_Rs,
    output logic [REG_ADDR_W-1:0] EX_Rt,
    output logic [REG_ADDR_W-1:0] EX_Rd,
    output logic                  HazardStall
);
    localparam int NREGS = 2 ** REG_ADDR_W;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_J     = 6'b000010;

    // Bit 7 of the control bundle is MemRead.
    localparam int CTRL_MEMREAD = 7;

    logic [DATA_W-1:0]     rf_q [NREGS];

    logic [5:0]            opcode;
    logic [REG_ADDR_W-1:0] rs_addr;
    logic [REG_ADDR_W-1:0] rt_addr;
    logic [REG_ADDR_W-1:0] rd_addr;
    logic [11:0]           ctrl_dec;
    logic [DATA_W-1:0]     imm_dec;
    logic [DATA_W-1:0]     rd1_dec;
    logic [DATA_W-1:0]     rd2_dec;
    logic                  wb_active;

    logic                  valid_q, valid_d;
    logic [11:0]           ctrl_q, ctrl_d;
    logic [DATA_W-1:0]     rd1_q, rd1_d;
    logic [DATA_W-1:0]     rd2_q, rd2_d;
    logic [DATA_W-1:0]     imm_q, imm_d;
    logic [4:0]            shamt_q, shamt_d;
    logic [REG_ADDR_W-1:0] rs_q, rs_d;
    logic [REG_ADDR_W-1:0] rt_q, rt_d;
    logic [REG_ADDR_W-1:0] rd_q, rd_d;

    assign opcode    = Instruction[31:26];
    assign rs_addr   = REG_ADDR_W'(Instruction[25:21]);
    assign rt_addr   = REG_ADDR_W'(Instruction[20:16]);
    assign rd_addr   = REG_ADDR_W'(Instruction[15:11]);
    assign wb_active = WB_RegWrite && (WB_WriteReg != '0);

    // Register file write; register 0 is never written and reads as zero.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
        end else if (wb_active) begin
            rf_q[WB_WriteReg] <= WB_WriteData;
        end
    end

    // Operand read with optional forwarding of the write happening this cycle.
    always_comb begin
        rd1_dec = rf_q[rs_addr];
        rd2_dec = rf_q[rt_addr];
        if ((BYPASS != 0) && wb_active && (WB_WriteReg == rs_addr)) rd1_dec = WB_WriteData;
        if ((BYPASS != 0) && wb_active && (WB_WriteReg == rt_addr)) rd2_dec = WB_WriteData;
        if (rs_addr == '0) rd1_dec = '0;
        if (rt_addr == '0) rd2_dec = '0;
    end

    // Control decode and immediate extension (logical immediates zero-extend).
    always_comb begin
        ctrl_dec = 12'h000;
        imm_dec  = {{(DATA_W-16){Instruction[15]}}, Instruction[15:0]};
        case (opcode)
            OP_RTYPE: ctrl_dec = 12'b1001_0000_1111;
            OP_LW:    ctrl_dec = 12'b0111_1000_0010;
            OP_SW:    ctrl_dec = 12'b0100_0100_0010;
            OP_BEQ:   ctrl_dec = 12'b0000_0010_0110;
            OP_ADDI:  ctrl_dec = 12'b0101_0000_0010;
            OP_ANDI: begin
                ctrl_dec = 12'b0101_0000_0000;
                imm_dec  = {{(DATA_W-16){1'b0}}, Instruction[15:0]};
            end
            OP_ORI: begin
                ctrl_dec = 12'b0101_0000_0001;
                imm_dec  = {{(DATA_W-16){1'b0}}, Instruction[15:0]};
            end
            OP_J:     ctrl_dec = 12'b0000_0001_0000;
            default:  ctrl_dec = 12'h000;
        endcase
    end

    // Load-use detection against the instruction currently held in ID/EX.
    assign HazardStall = InstrValid && valid_q && ctrl_q[CTRL_MEMREAD] && (rt_q != '0) &&
                         ((rt_q == rs_addr) || (rt_q == rt_addr));

    // ID/EX next state: flush beats stall beats bubble beats normal load.
    always_comb begin
        valid_d = InstrValid;
        ctrl_d  = InstrValid ? ctrl_dec : 12'h000;
        rd1_d   = rd1_dec;
        rd2_d   = rd2_dec;
        imm_d   = imm_dec;
        shamt_d = Instruction[10:6];
        rs_d    = rs_addr;
        rt_d    = rt_addr;
        rd_d    = rd_addr;
        if (Flush || (!Stall && HazardStall)) begin
            valid_d = 1'b0;
            ctrl_d  = 12'h000;
        end else if (Stall) begin
            valid_d = valid_q;
            ctrl_d  = ctrl_q;
            rd1_d   = rd1_q;
            rd2_d   = rd2_q;
            imm_d   = imm_q;
            shamt_d = shamt_q;
            rs_d    = rs_q;
            rt_d    = rt_q;
            rd_d    = rd_q;
        end
    end

    // ID/EX pipeline register.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            rd1_q   <= '0;
            rd2_q   <= '0;
            imm_q   <= '0;
            shamt_q <= '0;
            rs_q    <= '0;
            rt_q    <= '0;
            rd_q    <= '0;
        end else begin
            valid_q <= valid_d;
            ctrl_q  <= ctrl_d;
            rd1_q   <= rd1_d;
            rd2_q   <= rd2_d;
            imm_q   <= imm_d;
            shamt_q <= shamt_d;
            rs_q    <= rs_d;
            rt_q    <= rt_d;
            rd_q    <= rd_d;
        end
    end

    assign EX_Valid        = valid_q;
    assign EX_ControlLines = ctrl_q;
    assign EX_ReadData1    = rd1_q;
    assign EX_ReadData2    = rd2_q;
    assign EX_Imm          = imm_q;
    assign EX_shamt        = shamt_q;
    assign EX_Rs           = rs_q;
    assign EX_Rt           = rt_q;
    assign EX_Rd           = rd_q;
endmodule

// File: tb/tb_pipelined_decode.sv
// Bench for pipelined_decode: directed scenarios plus randomized traffic,
// compared every cycle against a behavioural ID-stage model.
module tb_pipelined_decode;
    localparam int DW = 32;
    localparam int AW = 5;

    logic          Clk = 1'b0;
    logic          Reset = 1'b1;
    logic [31:0]   Instruction = '0;
    logic          InstrValid = 1'b0;
    logic          Stall = 1'b0;
    logic          Flush = 1'b0;
    logic          WB_RegWrite = 1'b0;
    logic [AW-1:0] WB_WriteReg = '0;
    logic [DW-1:0] WB_WriteData = '0;

    logic          EX_Valid, HazardStall;
    logic [11:0]   EX_ControlLines;
    logic [DW-1:0] EX_ReadData1, EX_ReadData2, EX_Imm;
    logic [4:0]    EX_shamt;
    logic [AW-1:0] EX_Rs, EX_Rt, EX_Rd;

    logic          nb_Valid, nb_Hazard;
    logic [11:0]   nb_Ctrl;
    logic [DW-1:0] nb_Rd1, nb_Rd2, nb_Imm;
    logic [4:0]    nb_shamt;
    logic [AW-1:0] nb_Rs, nb_Rt, nb_Rd;

    pipelined_decode #(.DATA_W(DW), .REG_ADDR_W(AW), .BYPASS(1)) dut (
        .Clk(Clk), .Reset(Reset), .Instruction(Instruction), .InstrValid(InstrValid),
        .Stall(Stall), .Flush(Flush), .WB_RegWrite(WB_RegWrite), .WB_WriteReg(WB_WriteReg),
        .WB_WriteData(WB_WriteData), .EX_Valid(EX_Valid), .EX_ControlLines(EX_ControlLines),
        .EX_ReadData1(EX_ReadData1), .EX_ReadData2(EX_ReadData2), .EX_Imm(EX_Imm),
        .EX_shamt(EX_shamt), .EX_Rs(EX_Rs), .EX_Rt(EX_Rt), .EX_Rd(EX_Rd),
        .HazardStall(HazardStall));

    pipelined_decode #(.DATA_W(DW), .REG_ADDR_W(AW), .BYPASS(0)) u_nb (
        .Clk(Clk), .Reset(Reset), .Instruction(Instruction), .InstrValid(InstrValid),
        .Stall(Stall), .Flush(Flush), .WB_RegWrite(WB_RegWrite), .WB_WriteReg(WB_WriteReg),
        .WB_WriteData(WB_WriteData), .EX_Valid(nb_Valid), .EX_ControlLines(nb_Ctrl),
        .EX_ReadData1(nb_Rd1), .EX_ReadData2(nb_Rd2), .EX_Imm(nb_Imm),
        .EX_shamt(nb_shamt), .EX_Rs(nb_Rs), .EX_Rt(nb_Rt), .EX_Rd(nb_Rd),
        .HazardStall(nb_Hazard));

    always #5 Clk = ~Clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [DW-1:0] m_regs [32];
    logic          m_valid;
    logic [11:0]   m_ctrl;
    logic [DW-1:0] m_rd1, m_rd2, m_imm;
    logic [4:0]    m_shamt, m_rs, m_rt, m_rd;

    function automatic logic [11:0] ctrl_of(input logic [5:0] op);
        case (op)
            6'h00:   return 12'h90F;  // R-type
            6'h23:   return 12'h782;  // lw
            6'h2B:   return 12'h442;  // sw
            6'h04:   return 12'h026;  // beq
            6'h08:   return 12'h502;  // addi
            6'h0C:   return 12'h500;  // andi
            6'h0D:   return 12'h501;  // ori
            6'h02:   return 12'h010;  // j
            default: return 12'h000;
        endcase
    endfunction

    function automatic logic [DW-1:0] imm_of(input logic [31:0] ins);
        int v;
        if (ins[31:26] == 6'h0C || ins[31:26] == 6'h0D) return DW'(ins[15:0]);
        v = int'($signed(ins[15:0]));
        return DW'(v);
    endfunction

    function automatic logic [DW-1:0] read_reg(input logic [4:0] a);
        if (a == 0) return '0;
        if (WB_RegWrite && WB_WriteReg == a) return WB_WriteData;
        return m_regs[a];
    endfunction

    function automatic logic m_hazard();
        logic [4:0] rs, rt;
        logic       ex_is_load;
        rs = Instruction[25:21];
        rt = Instruction[20:16];
        ex_is_load = m_valid && (m_ctrl == ctrl_of(6'h23));
        return InstrValid && ex_is_load && m_rt != 0 && (m_rt == rs || m_rt == rt);
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 32; i++) m_regs[i] = '0;
        m_valid = 0; m_ctrl = '0; m_rd1 = '0; m_rd2 = '0; m_imm = '0;
        m_shamt = '0; m_rs = '0; m_rt = '0; m_rd = '0;
    endtask

    // Model advances on the same events as the design.
    initial begin
        model_clear();
        forever begin
            @(posedge Clk or posedge Reset);
            if (Reset) begin
                model_clear();
            end else begin
                logic hz;
                hz = m_hazard();
                if (!(Stall && !Flush)) begin
                    m_rd1   = read_reg(Instruction[25:21]);
                    m_rd2   = read_reg(Instruction[20:16]);
                    m_imm   = imm_of(Instruction);
                    m_shamt = Instruction[10:6];
                    m_rs    = Instruction[25:21];
                    m_rt    = Instruction[20:16];
                    m_rd    = Instruction[15:11];
                    if (Flush || hz) begin
                        m_valid = 0;
                        m_ctrl  = '0;
                    end else begin
                        m_valid = InstrValid;
                        m_ctrl  = InstrValid ? ctrl_of(Instruction[31:26]) : 12'h000;
                    end
                end
                if (WB_RegWrite && WB_WriteReg != 0) m_regs[WB_WriteReg] = WB_WriteData;
            end
        end
    end

    // Compare process: checks every cycle on the falling edge.
    initial begin
        forever begin
            @(negedge Clk);
            check("valid", 64'(EX_Valid), 64'(m_valid));
            check("ctrl", 64'(EX_ControlLines), 64'(m_ctrl));
            check("hazard", 64'(HazardStall), 64'(m_hazard()));
            if (m_valid) begin
                check("rd1", 64'(EX_ReadData1), 64'(m_rd1));
                check("rd2", 64'(EX_ReadData2), 64'(m_rd2));
                check("imm", 64'(EX_Imm), 64'(m_imm));
                check("shamt", 64'(EX_shamt), 64'(m_shamt));
                check("rs", 64'(EX_Rs), 64'(m_rs));
                check("rt", 64'(EX_Rt), 64'(m_rt));
                check("rd", 64'(EX_Rd), 64'(m_rd));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic [31:0] ins, input logic v, input logic st, input logic fl,
                         input logic we, input logic [4:0] wr, input logic [31:0] wd);
        @(posedge Clk);
        #2;
        Instruction = ins; InstrValid = v; Stall = st; Flush = fl;
        WB_RegWrite = we; WB_WriteReg = wr; WB_WriteData = wd;
    endtask

    task automatic idle();
        drive(32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    endtask

    task automatic at_neg();
        @(negedge Clk);
        #1;
    endtask

    localparam logic [31:0] I_ADD    = 32'h02324020; // add r8, r17, r18
    localparam logic [31:0] I_RD9    = 32'h01200820; // add r1, r9, r0
    localparam logic [31:0] I_ADDI   = 32'h2001FFFF;
    localparam logic [31:0] I_ORI    = 32'h3401FFFF;
    localparam logic [31:0] I_LW8    = 32'h8C080000; // lw r8, 0(r0)
    localparam logic [31:0] I_USE8   = 32'h01001820; // add r3, r8, r0
    localparam logic [31:0] I_LW0    = 32'h8C000000; // lw r0, 0(r0)
    localparam logic [31:0] I_USE0   = 32'h00001820; // add r3, r0, r0

    initial begin
        logic [5:0]  ops [9];
        logic [31:0] ins;
        ops = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h08, 6'h0C, 6'h0D, 6'h02, 6'h3F};

        repeat (2) at_neg();
        check("reset_valid", 64'(EX_Valid), 64'd0);
        check("reset_ctrl", 64'(EX_ControlLines), 64'd0);
        @(posedge Clk); #2 Reset = 1'b0;

        // Basic add with operands written through WB
        drive(32'h0, 0, 0, 0, 1, 5'd17, 32'd5);
        drive(32'h0, 0, 0, 0, 1, 5'd18, 32'd7);
        drive(I_ADD, 1, 0, 0, 0, 5'd0, 32'h0);
        idle(); at_neg();
        check("add_rd1", 64'(EX_ReadData1), 64'd5);
        check("add_rd2", 64'(EX_ReadData2), 64'd7);
        check("add_ctrl", 64'(EX_ControlLines), 64'h90F);
        check("add_rd", 64'(EX_Rd), 64'd8);
        check("add_valid", 64'(EX_Valid), 64'd1);

        // Same-cycle bypass, and the non-bypassing variant
        drive(I_RD9, 1, 0, 0, 1, 5'd9, 32'hDEADBEEF);
        idle(); at_neg();
        check("bypass_rd1", 64'(EX_ReadData1), 64'hDEADBEEF);
        check("nobypass_rd1", 64'(nb_Rd1), 64'h0);

        // Immediate extension
        drive(I_ADDI, 1, 0, 0, 0, 5'd0, 32'h0);
        idle(); at_neg();
        check("addi_imm", 64'(EX_Imm), 64'hFFFFFFFF);
        drive(I_ORI, 1, 0, 0, 0, 5'd0, 32'h0);
        idle(); at_neg();
        check("ori_imm", 64'(EX_Imm), 64'h0000FFFF);

        // Load-use: one stall cycle, one bubble, then the consumer loads
        drive(I_LW8, 1, 0, 0, 0, 5'd0, 32'h0);
        drive(I_USE8, 1, 0, 0, 0, 5'd0, 32'h0); at_neg();
        check("lu_hazard", 64'(HazardStall), 64'd1);
        check("lu_lw_ctrl", 64'(EX_ControlLines), 64'h782);
        drive(I_USE8, 1, 0, 0, 0, 5'd0, 32'h0); at_neg();
        check("lu_bubble_valid", 64'(EX_Valid), 64'd0);
        check("lu_hazard_clear", 64'(HazardStall), 64'd0);
        idle(); at_neg();
        check("lu_use_valid", 64'(EX_Valid), 64'd1);
        check("lu_use_ctrl", 64'(EX_ControlLines), 64'h90F);
        drive(I_LW0, 1, 0, 0, 0, 5'd0, 32'h0);
        drive(I_USE0, 1, 0, 0, 0, 5'd0, 32'h0); at_neg();
        check("lu_r0_nohazard", 64'(HazardStall), 64'd0);

        // Register 0 stays zero
        drive(32'h0, 0, 0, 0, 1, 5'd0, 32'h1234);
        drive(I_USE0, 1, 0, 0, 0, 5'd0, 32'h0);
        idle(); at_neg();
        check("r0_rd1", 64'(EX_ReadData1), 64'h0);

        // Stall holds for three cycles, then flush with stall empties ID/EX
        drive(I_ADD, 1, 0, 0, 0, 5'd0, 32'h0);
        drive(I_ORI, 1, 1, 0, 0, 5'd0, 32'h0); at_neg();
        for (int k = 0; k < 3; k++) begin
            drive(I_ORI, 1, 1, 0, 0, 5'd0, 32'h0); at_neg();
            check("stall_ctrl", 64'(EX_ControlLines), 64'h90F);
            check("stall_rd1", 64'(EX_ReadData1), 64'd5);
            check("stall_rd", 64'(EX_Rd), 64'd8);
        end
        drive(I_ORI, 1, 1, 1, 0, 5'd0, 32'h0);
        idle(); at_neg();
        check("flush_valid", 64'(EX_Valid), 64'd0);

        // Asynchronous reset mid-stream
        drive(I_ADD, 1, 0, 0, 0, 5'd0, 32'h0);
        idle(); at_neg();
        check("pre_reset_valid", 64'(EX_Valid), 64'd1);
        @(posedge Clk); #3 Reset = 1'b1;
        #1;
        check("areset_valid", 64'(EX_Valid), 64'd0);
        check("areset_ctrl", 64'(EX_ControlLines), 64'd0);
        check("areset_rd1", 64'(EX_ReadData1), 64'd0);
        check("areset_rd", 64'(EX_Rd), 64'd0);
        @(posedge Clk); #2 Reset = 1'b0;
        drive(I_ADD, 1, 0, 0, 0, 5'd0, 32'h0);
        idle(); at_neg();
        check("post_reset_valid", 64'(EX_Valid), 64'd1);
        check("post_reset_rd1", 64'(EX_ReadData1), 64'd0);

        // Randomized traffic; small register indices provoke hazards and bypasses
        for (int n = 0; n < 1500; n++) begin
            ins = {ops[$urandom_range(0, 8)], 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                   5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 6'($urandom_range(0, 63))};
            drive(ins, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 9) == 0),
                  1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 1)),
                  5'($urandom_range(0, 7)), $urandom());
        end
        idle();
        repeat (2) at_neg();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
